core_dmem: RTL and testbench

Data-memory responder for the multi-cycle RV32I core. It services the core's load/store port: byte-addressed RAM with byte-lane writes, a registered read path, and load alignment plus sign/zero extension. It also decodes a small MMIO window holding a console output FIFO, a status word and a free-running cycle counter. It sits between `core_top` and the board-level console sink.

---
 rtl/core_pkg.sv | 36 +++
 rtl/core_dmem_if.sv | 26 ++
 rtl/core_dmem_fifo.sv | 58 +++++
 rtl/core_dmem.sv | 131 +++++++++++++
 tb/tb_core_dmem.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared encodings for the RV32I core's data-memory path.
//   size_e        : load/store access size (MEM_SIZE encoding)
//   MMIO_*        : word offsets inside the 16-byte MMIO window
//   MMIO_BASE_DEFAULT : default base address of the MMIO window
//   load_extend() : lane select plus sign/zero extension for loads
package core_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  localparam logic [3:0] MMIO_CONSOLE = 4'h0;
  localparam logic [3:0] MMIO_STATUS  = 4'h4;
  localparam logic [3:0] MMIO_CYCLE   = 4'h8;
  localparam logic [3:0] MMIO_RSVD    = 4'hC;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FF00;

  // Shift the addressed lane(s) down to bit 0 and extend; word loads pass through.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input size_e       size,
                                              input logic        is_unsigned);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_B:    return is_unsigned ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    return is_unsigned ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/core_dmem_if.sv
// core_dmem_if: load/store port of the core plus the console sink handshake.
//   master : core/sink side (drives request, store data, CON_READY)
//   slave  : core_dmem side (drives MEM_IN, MEM_ERR, CON_DATA, CON_VALID)
interface core_dmem_if;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_DATA;
  logic        MEM_WE;
  logic        MEM_RE;
  logic [1:0]  MEM_SIZE;
  logic        MEM_UNSIGNED;
  logic [31:0] MEM_IN;
  logic        MEM_ERR;
  logic [7:0]  CON_DATA;
  logic        CON_VALID;
  logic        CON_READY;

  modport master (
    output MEM_ADDR, MEM_DATA, MEM_WE, MEM_RE, MEM_SIZE, MEM_UNSIGNED, CON_READY,
    input  MEM_IN, MEM_ERR, CON_DATA, CON_VALID
  );

  modport slave (
    input  MEM_ADDR, MEM_DATA, MEM_WE, MEM_RE, MEM_SIZE, MEM_UNSIGNED, CON_READY,
    output MEM_IN, MEM_ERR, CON_DATA, CON_VALID
  );
endinterface

// File: rtl/core_dmem_fifo.sv
// core_dmem_fifo: synchronous FIFO with a combinational head output.
//   i_clk, i_rst_n : clock, async active-low reset (flushes pointers, count, storage)
//   i_push/i_data  : write request and data; accepted when not full or popping
//   i_pop          : read request; ignored when empty
//   o_data         : head entry
//   o_full/o_empty/o_count : occupancy
module core_dmem_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A pop frees the slot the same cycle, so a push on full is allowed alongside it.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/core_dmem.sv
// core_dmem: data-memory responder for the multi-cycle RV32I core.
//   CLK, RST_N : clock, async active-low reset
//   bus        : core_dmem_if.slave -- load/store request, MEM_IN/MEM_ERR
//                response, console FIFO head (CON_DATA/CON_VALID/CON_READY)
// Byte-lane RAM below 2^ADDR_WIDTH; 16-byte MMIO window at MMIO_BASE with
// CONSOLE (+0), STATUS (+4), CYCLE (+8), reserved (+C).
module core_dmem
  import core_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic CLK,
  input  logic RST_N,
  core_dmem_if.slave bus
);
  localparam int unsigned WORDS = 2 ** (ADDR_WIDTH - 2);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]           r_mem_in;
  logic                  r_err;
  logic [31:0]           r_cycle;

  size_e                 w_size;
  logic [3:0]            w_off;
  logic [ADDR_WIDTH-3:0] w_widx;
  logic                  w_req, w_rd;
  logic                  w_in_ram, w_in_mmio;
  logic                  w_bad_align, w_mmio_bad, w_access_err;
  logic                  w_ok, w_push_req, w_drop, w_err;
  logic                  w_cyc_we;
  logic [3:0]            w_be, w_ram_be;
  logic [31:0]           w_rword, w_rdata;
  logic                  w_full, w_empty, w_pop;
  logic [CW-1:0]         w_count;
  logic [2:0]            w_cnt3;

  assign w_size    = size_e'(bus.MEM_SIZE);
  assign w_off     = bus.MEM_ADDR[3:0];
  assign w_widx    = bus.MEM_ADDR[ADDR_WIDTH-1:2];
  assign w_req     = bus.MEM_WE | bus.MEM_RE;
  assign w_rd      = bus.MEM_RE & ~bus.MEM_WE;
  assign w_in_ram  = (bus.MEM_ADDR[31:ADDR_WIDTH] == '0);
  assign w_in_mmio = ~w_in_ram & (bus.MEM_ADDR[31:4] == MMIO_BASE[31:4]);

  always_comb begin
    w_bad_align = 1'b0;
    w_be        = '0;
    case (w_size)
      SZ_B: w_be = 4'b0001 << bus.MEM_ADDR[1:0];
      SZ_H: begin
        w_bad_align = bus.MEM_ADDR[0];
        w_be        = bus.MEM_ADDR[1] ? 4'b1100 : 4'b0011;
      end
      SZ_W: begin
        w_bad_align = (bus.MEM_ADDR[1:0] != 2'b00);
        w_be        = 4'b1111;
      end
      default: w_bad_align = 1'b1;
    endcase
  end

  assign w_mmio_bad   = w_in_mmio & ((w_size != SZ_W) |
                        (bus.MEM_WE & ((w_off == MMIO_STATUS) | (w_off == MMIO_RSVD))));
  assign w_access_err = w_req & (w_bad_align | w_mmio_bad | (~w_in_ram & ~w_in_mmio));
  assign w_ok         = w_req & ~w_access_err;

  assign w_pop      = ~w_empty & bus.CON_READY;
  assign w_push_req = w_ok & bus.MEM_WE & w_in_mmio & (w_off == MMIO_CONSOLE);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  // Simultaneous WE+RE still performs the write but is flagged.
  assign w_err      = w_access_err | (bus.MEM_WE & bus.MEM_RE) | w_drop;

  assign w_cyc_we = w_ok & bus.MEM_WE & w_in_mmio & (w_off == MMIO_CYCLE);
  assign w_ram_be = (w_ok & bus.MEM_WE & w_in_ram) ? w_be : 4'b0000;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] r_lane [WORDS];
    always_ff @(posedge CLK) begin
      if (w_ram_be[g]) r_lane[w_widx] <= bus.MEM_DATA[8*g +: 8];
    end
    assign w_rword[8*g +: 8] = r_lane[w_widx];
  end

  assign w_cnt3 = 3'(w_count);

  always_comb begin
    w_rdata = '0;
    if (w_in_ram) begin
      w_rdata = load_extend(w_rword, bus.MEM_ADDR[1:0], w_size, bus.MEM_UNSIGNED);
    end else begin
      case (w_off)
        MMIO_STATUS: w_rdata = {27'b0, w_cnt3, w_full, w_empty};
        MMIO_CYCLE:  w_rdata = r_cycle;
        default:     w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mem_in <= '0;
      r_err    <= 1'b0;
      r_cycle  <= '0;
    end else begin
      r_err   <= w_err;
      r_cycle <= w_cyc_we ? bus.MEM_DATA : r_cycle + 32'd1;
      if (w_rd) r_mem_in <= w_access_err ? '0 : w_rdata;
    end
  end

  core_dmem_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_con_fifo (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_push  (w_push_req & ~w_drop),
    .i_data  (bus.MEM_DATA[7:0]),
    .i_pop   (w_pop),
    .o_data  (bus.CON_DATA),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.CON_VALID = ~w_empty;
  assign bus.MEM_IN    = r_mem_in;
  assign bus.MEM_ERR   = r_err;
endmodule

// File: tb/tb_core_dmem.sv
module tb_core_dmem;
  import core_pkg::*;

  localparam logic [31:0] MB = 32'hFFFF_FF00;

  logic CLK;
  logic RST_N;
  core_dmem_if bus();

  core_dmem #(
    .ADDR_WIDTH(12),
    .MMIO_BASE (MB),
    .FIFO_DEPTH(4)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [31:0] in;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  con_q[$];
  logic [31:0] model_in;
  int unsigned n_checks;
  int unsigned n_errs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request cycle: drive at negedge, compare response 1 after the closing posedge.
  task automatic req(input string tag, input bit we, input bit re, input logic [31:0] a,
                     input logic [31:0] d, input logic [1:0] sz, input bit u,
                     input logic [31:0] rexp, input bit eexp);
    exp_t e;
    @(negedge CLK);
    bus.MEM_ADDR     = a;
    bus.MEM_DATA     = d;
    bus.MEM_WE       = we;
    bus.MEM_RE       = re;
    bus.MEM_SIZE     = sz;
    bus.MEM_UNSIGNED = u;
    if (re && !we) model_in = rexp;
    e.in  = model_in;
    e.err = eexp;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    bus.MEM_WE = 1'b0;
    bus.MEM_RE = 1'b0;
    e = exp_q.pop_front();
    check({tag, "_in"}, bus.MEM_IN, e.in);
    check({tag, "_err"}, 32'(bus.MEM_ERR), 32'(e.err));
  endtask

  task automatic idle();
    @(negedge CLK);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errs   = 0;
    model_in = '0;
    RST_N            = 1'b0;
    bus.MEM_ADDR     = '0;
    bus.MEM_DATA     = '0;
    bus.MEM_WE       = 1'b0;
    bus.MEM_RE       = 1'b0;
    bus.MEM_SIZE     = SZ_W;
    bus.MEM_UNSIGNED = 1'b0;
    bus.CON_READY    = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_in",    bus.MEM_IN, 32'h0);
    check("rst_err",   32'(bus.MEM_ERR), 32'h0);
    check("rst_valid", 32'(bus.CON_VALID), 32'h0);
    check("rst_data",  32'(bus.CON_DATA), 32'h0);
    RST_N = 1'b1;

    // RAM: store, reload, lanes, extension
    req("sw",   1, 0, 32'h10, 32'hDEADBEEF, SZ_W, 0, 0, 0);
    req("lw",   0, 1, 32'h10, 0, SZ_W, 0, 32'hDEADBEEF, 0);
    req("lb",   0, 1, 32'h13, 0, SZ_B, 0, 32'hFFFFFFDE, 0);
    req("lbu",  0, 1, 32'h13, 0, SZ_B, 1, 32'h000000DE, 0);
    req("lh",   0, 1, 32'h10, 0, SZ_H, 0, 32'hFFFFBEEF, 0);
    req("lhu",  0, 1, 32'h12, 0, SZ_H, 1, 32'h0000DEAD, 0);
    req("lwu",  0, 1, 32'h10, 0, SZ_W, 1, 32'hDEADBEEF, 0);
    req("sb",   1, 0, 32'h11, 32'h7F7F7F7F, SZ_B, 0, 0, 0);
    req("lw2",  0, 1, 32'h10, 0, SZ_W, 0, 32'hDEAD7FEF, 0);
    // errors
    req("lwmis", 0, 1, 32'h12, 0, SZ_W, 0, 32'h0, 1);
    req("shmis", 1, 0, 32'h11, 32'h12341234, SZ_H, 0, 0, 1);
    req("lw3",  0, 1, 32'h10, 0, SZ_W, 0, 32'hDEAD7FEF, 0);
    req("sz11", 0, 1, 32'h10, 0, 2'b11, 0, 32'h0, 1);
    req("oor",  0, 1, 32'h1000, 0, SZ_W, 0, 32'h0, 1);
    req("swoor", 1, 0, 32'h1010, 32'h0BADF00D, SZ_W, 0, 0, 1);
    req("lw4",  0, 1, 32'h10, 0, SZ_W, 0, 32'hDEAD7FEF, 0);
    req("werw", 1, 1, 32'h14, 32'h12345678, SZ_W, 0, 0, 1);
    req("lw5",  0, 1, 32'h14, 0, SZ_W, 0, 32'h12345678, 0);
    // MMIO
    req("st0",  0, 1, MB + 32'h4, 0, SZ_W, 0, 32'h1, 0);
    req("rsvd", 0, 1, MB + 32'hC, 0, SZ_W, 0, 32'h0, 0);
    req("stb",  0, 1, MB + 32'h4, 0, SZ_B, 0, 32'h0, 1);
    req("stwr", 1, 0, MB + 32'h4, 32'h5, SZ_W, 0, 0, 1);
    req("rswr", 1, 0, MB + 32'hC, 32'h5, SZ_W, 0, 0, 1);
    req("conr", 0, 1, MB, 0, SZ_W, 0, 32'h0, 0);
    // console fill with sink stalled
    for (int unsigned i = 0; i < 5; i++)
      req("push", 1, 0, MB, 32'h41 + i, SZ_W, 0, 0, (i == 4));
    req("stfull", 0, 1, MB + 32'h4, 0, SZ_W, 0, 32'h12, 0);
    check("head0", 32'(bus.CON_DATA), 32'h41);
    check("valid0", 32'(bus.CON_VALID), 32'h1);
    // push while full and the sink pops 0x41 in the same cycle
    bus.CON_READY = 1'b1;
    req("pushpop", 1, 0, MB, 32'h55, SZ_W, 0, 0, 0);
    bus.CON_READY = 1'b0;
    check("head1", 32'(bus.CON_DATA), 32'h42);
    req("stfull2", 0, 1, MB + 32'h4, 0, SZ_W, 0, 32'h12, 0);
    con_q = '{8'h42, 8'h43, 8'h44, 8'h55};
    bus.CON_READY = 1'b1;
    for (int i = 0; i < 10 && con_q.size() > 0; i++) begin
      check("drain_valid", 32'(bus.CON_VALID), 32'h1);
      check("drain_data", 32'(bus.CON_DATA), 32'(con_q.pop_front()));
      @(posedge CLK);
      #1;
    end
    check("drain_left", 32'(con_q.size()), 32'h0);
    check("drain_empty", 32'(bus.CON_VALID), 32'h0);
    bus.CON_READY = 1'b0;
    req("stempty", 0, 1, MB + 32'h4, 0, SZ_W, 0, 32'h1, 0);
    // cycle counter load and wrap
    req("cycw",  1, 0, MB + 32'h8, 32'hFFFFFFFE, SZ_W, 0, 0, 0);
    req("cycr0", 0, 1, MB + 32'h8, 0, SZ_W, 0, 32'hFFFFFFFE, 0);
    idle();
    req("cycr1", 0, 1, MB + 32'h8, 0, SZ_W, 0, 32'h0, 0);
    // reset mid-drain
    req("pushr0", 1, 0, MB, 32'h61, SZ_W, 0, 0, 0);
    req("pushr1", 1, 0, MB, 32'h62, SZ_W, 0, 0, 0);
    bus.CON_READY = 1'b1;
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_valid", 32'(bus.CON_VALID), 32'h0);
    check("arst_data",  32'(bus.CON_DATA), 32'h0);
    check("arst_in",    bus.MEM_IN, 32'h0);
    check("arst_err",   32'(bus.MEM_ERR), 32'h0);
    bus.CON_READY = 1'b0;
    model_in = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    req("cycrst", 0, 1, MB + 32'h8, 0, SZ_W, 0, 32'h1, 0);
    req("strst",  0, 1, MB + 32'h4, 0, SZ_W, 0, 32'h1, 0);
    req("lwrst",  0, 1, 32'h10, 0, SZ_W, 0, 32'hDEAD7FEF, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
